// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic lab datapath (multiplier and divider).
`timescale 1ns/1ps
package arith_pkg;

    // Width defaults shared with the 4x4 array multiplier:
    // the dividend matches the product width, the divisor matches the operand width.
    localparam int DIVIDEND_W = 8;
    localparam int DIVISOR_W  = 4;

    // Divider control states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then subtract the divisor if it fits.
`timescale 1ns/1ps
module div_step #(
    parameter int DIVISOR_W = 4
) (
    input  logic [DIVISOR_W:0]   r,
    input  logic                 din,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   r_next,
    output logic                 q_bit
);

    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W+1:0] divisor_ext;

    // Compare-and-restore on the shifted partial remainder. R is always below
    // the divisor, so the shifted value fits and the result fits R's width.
    always_comb begin
        shifted     = {r, din};
        divisor_ext = {2'b00, divisor};
        q_bit       = (shifted >= divisor_ext);
        if (q_bit) begin
            r_next = (DIVISOR_W+1)'(shifted - divisor_ext);
        end else begin
            r_next = (DIVISOR_W+1)'(shifted);
        end
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned sequential restoring divider, one quotient bit per clock.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and an offered result is held
// stable until it is taken.
`timescale 1ns/1ps
module seq_restoring_divider #(
    parameter int DIVIDEND_W = arith_pkg::DIVIDEND_W,
    parameter int DIVISOR_W  = arith_pkg::DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero
);

    import arith_pkg::*;

    localparam int CW = $clog2(DIVIDEND_W + 1);

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         count;
    logic [DIVIDEND_W-1:0] dq;        // dividend shifting out, quotient shifting in
    logic [DIVISOR_W:0]    rem_part;  // partial remainder R
    logic [DIVISOR_W-1:0]  dsr;       // latched divisor
    logic [DIVISOR_W:0]    step_r;
    logic                  step_q;
    logic                  last_step;

    assign last_step = (count == CW'(1));
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .r       (rem_part),
        .din     (dq[DIVIDEND_W-1]),
        .divisor (dsr),
        .r_next  (step_r),
        .q_bit   (step_q)
    );

    // State register; reset returns to IDLE and abandons any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: divide-by-zero skips RUN and reports at once.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_next = (divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_step) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, and result registers that only
    // change when entering DONE (or on reset).
    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            dq        <= '0;
            rem_part  <= '0;
            dsr       <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= '0;
                            div_zero  <= 1'b1;
                        end else begin
                            dq       <= dividend;
                            rem_part <= '0;
                            dsr      <= divisor;
                            count    <= CW'(DIVIDEND_W);
                        end
                    end
                end
                S_RUN: begin
                    dq       <= {dq[DIVIDEND_W-2:0], step_q};
                    rem_part <= step_r;
                    count    <= count - CW'(1);
                    if (last_step) begin
                        quotient  <= {dq[DIVIDEND_W-2:0], step_q};
                        remainder <= step_r[DIVISOR_W-1:0];
                        div_zero  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Testbench for seq_restoring_divider: directed cases plus random operands,
// results checked by a queue-based scoreboard against plain integer division.
`timescale 1ns/1ps
module tb_seq_restoring_divider;

    localparam int DW = 8;
    localparam int VW = 4;

    // ---------------- clock / reset / signals ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;

    always #5 clk = ~clk;

    seq_restoring_divider #(
        .DIVIDEND_W (DW),
        .DIVISOR_W  (VW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    // ---------------- scoreboard ----------------
    logic [DW+VW:0] exp_q[$];   // {quotient, remainder, div_zero}
    int  checks = 0;
    int  passes = 0;
    bit  rand_ready = 1'b0;

    // Reference: plain integer division; divide-by-zero reports all-ones quotient.
    function automatic logic [DW+VW:0] model(input int a, input int b);
        if (b == 0) return {{DW{1'b1}}, {VW{1'b0}}, 1'b1};
        return {DW'(a / b), VW'(a % b), 1'b0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act === exp_v) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    endtask

    // Monitor: every accepted result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_result: got q=%0d r=%0d dz=%0b with nothing expected",
                         quotient, remainder, div_zero);
            end else begin
                check("result", 32'({quotient, remainder, div_zero}), 32'(exp_q.pop_front()));
                check("in_ready_in_done", 32'(in_ready), 32'd0);
            end
        end
    end

    // Random consumer backpressure while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int guard = 0;
        while (!in_ready && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL idle_timeout: in_ready=%0b required 1", in_ready);
        end
    endtask

    // Issue one operation, record its expected result, and check the latency
    // from the accept edge (counted as edge 1) to out_valid.
    task automatic send(input int a, input int b, input bit hold_valid);
        int lat;
        wait_idle();
        in_valid = 1'b1;
        dividend = DW'(a);
        divisor  = VW'(b);
        @(posedge clk);
        exp_q.push_back(model(a, b));
        #1;
        if (hold_valid) begin
            dividend = DW'($urandom);
            divisor  = VW'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", 32'(lat), (b == 0) ? 32'd1 : 32'(DW + 1));
    endtask

    // ---------------- main sequence ----------------
    int edge_a[5] = '{255, 5, 0, 255, 254};
    int edge_b[5] = '{1, 9, 3, 15, 15};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_quotient",  32'(quotient),  32'd0);
        check("reset_remainder", 32'(remainder), 32'd0);
        check("reset_div_zero",  32'(div_zero),  32'd0);
        rst = 1'b0;

        // Basic case, then outputs must hold in IDLE with out_valid low.
        send(200, 7, 1'b0);
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
        check("idle_hold", 32'({quotient, remainder, out_valid}), 32'({8'd28, 4'd4, 1'b0}));

        // Multiplier round trip.
        send(225, 15, 1'b0);
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                send(a * b, b, 1'b0);
            end
        end

        // Edge cases.
        for (int i = 0; i < 5; i++) send(edge_a[i], edge_b[i], 1'b0);

        // Divide by zero.
        send(42, 0, 1'b0);

        // in_valid held through RUN/DONE must not disturb the operation.
        send(77, 5, 1'b1);

        // Backpressure: result held stable for 20 cycles.
        wait_idle();
        out_ready = 1'b0;
        send(100, 3, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold", 32'({out_valid, in_ready, quotient, remainder}),
                  32'({1'b1, 1'b0, 8'd33, 4'd1}));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", 32'({out_valid, in_ready}), 32'({1'b0, 1'b1}));

        // Reset four cycles into a run discards it.
        wait_idle();
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrun_reset",
              32'({out_valid, in_ready, quotient, remainder, div_zero}),
              32'({1'b0, 1'b1, 8'd0, 4'd0, 1'b0}));
        rst = 1'b0;
        send(9, 2, 1'b0);

        // Random operands with random consumer backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        // Drain the scoreboard.
        for (int g = 0; g < 50 && exp_q.size() != 0; g++) begin
            @(posedge clk);
            #1;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
